fft16_frame_ctrl: RTL

Frame sequencer for the 16-point parallel FFT datapath (the chain of registered butterfly stages).
- Collects 16 serial complex samples into a frame buffer and presents them in parallel to the datapath.
- Launches the datapath, waits its fixed pipeline latency, then captures the 16 parallel results.
- Streams the results out serially under valid/ready, optionally reordered from bit-reversed to natural order.
- Sits between the sample source/sink and the FFT datapath; one frame in flight at a time.

---
 rtl/fft16_pkg.sv | 24 ++
 rtl/fft16_frame_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point FFT frame controller and its bench.
package fft16_pkg;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int DW    = 17;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Lane i of a flattened N*DW parallel bus.
    function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] bus, input int i);
        return bus[i*DW +: DW];
    endfunction

endpackage

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer: gathers 16 serial samples, launches the parallel FFT datapath,
// captures its results after a fixed latency and streams them back out serially.
//
// state  | meaning
// LOAD   | accepting input samples into the frame buffer
// LAUNCH | one-cycle fft_start pulse, frame stable on fft_in_*
// WAIT   | counting down datapath latency, capture on the last cycle
// UNLOAD | streaming captured results out under valid/ready
module fft16_frame_ctrl
    import fft16_pkg::*;
#(
    parameter int DW         = 17,
    parameter int PIPE_LAT   = 4,
    parameter int BITREV_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_re,
    input  logic [DW-1:0]     s_im,
    output logic [16*DW-1:0]  fft_in_re,
    output logic [16*DW-1:0]  fft_in_im,
    output logic              fft_start,
    input  logic [16*DW-1:0]  fft_out_re,
    input  logic [16*DW-1:0]  fft_out_im,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_re,
    output logic [DW-1:0]     m_im,
    output logic [3:0]        m_idx,
    output logic              m_last,
    output logic              busy
);

    localparam logic [3:0] LAT_INIT = 4'(PIPE_LAT);

    state_t     state_q, state_d;
    logic [3:0] in_cnt_q, in_cnt_d;
    logic [3:0] out_cnt_q, out_cnt_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;
    logic       in_we, res_we;
    logic [3:0] out_lane;

    logic [DW-1:0] in_re_q  [16];
    logic [DW-1:0] in_im_q  [16];
    logic [DW-1:0] res_re_q [16];
    logic [DW-1:0] res_im_q [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        lat_cnt_d = lat_cnt_q;
        in_we     = 1'b0;
        res_we    = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    in_we    = 1'b1;
                    in_cnt_d = in_cnt_q + 4'd1;
                    if (in_cnt_q == 4'd15) state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                lat_cnt_d = LAT_INIT;
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    res_we  = 1'b1;
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                if (m_ready) begin
                    out_cnt_d = out_cnt_q + 4'd1;
                    if (out_cnt_q == 4'd15) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Input buffer only changes in LOAD, which keeps fft_in_* stable through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                in_re_q[i]  <= '0;
                in_im_q[i]  <= '0;
                res_re_q[i] <= '0;
                res_im_q[i] <= '0;
            end
        end else begin
            if (in_we) begin
                in_re_q[in_cnt_q] <= s_re;
                in_im_q[in_cnt_q] <= s_im;
            end
            if (res_we) begin
                for (int i = 0; i < 16; i++) begin
                    res_re_q[i] <= fft_out_re[i*DW +: DW];
                    res_im_q[i] <= fft_out_im[i*DW +: DW];
                end
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_fft_in
        assign fft_in_re[g*DW +: DW] = in_re_q[g];
        assign fft_in_im[g*DW +: DW] = in_im_q[g];
    end

    assign out_lane  = (BITREV_OUT != 0) ? bitrev4(out_cnt_q) : out_cnt_q;
    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign fft_start = (state_q == LAUNCH);
    assign m_valid   = (state_q == UNLOAD);
    assign m_last    = m_valid && (out_cnt_q == 4'd15);
    assign m_idx     = out_cnt_q;
    assign m_re      = res_re_q[out_lane];
    assign m_im      = res_im_q[out_lane];

endmodule
